// File: rtl/audio_sample_scheduler_if.sv
// Stereo sample handshake from the audio source and the strobed word toward the hdmi audio path.
interface audio_sample_scheduler_if #(
  parameter int unsigned AUDIO_BIT_WIDTH = 16
);
  logic                       src_valid;
  logic [AUDIO_BIT_WIDTH-1:0] src_left;
  logic [AUDIO_BIT_WIDTH-1:0] src_right;
  logic                       src_ready;
  logic                       sample_strobe;
  logic [AUDIO_BIT_WIDTH-1:0] audio_left;
  logic [AUDIO_BIT_WIDTH-1:0] audio_right;

  modport master (
    output src_valid, src_left, src_right,
    input  src_ready, sample_strobe, audio_left, audio_right
  );

  modport slave (
    input  src_valid, src_left, src_right,
    output src_ready, sample_strobe, audio_left, audio_right
  );
endinterface

// File: rtl/audio_sample_scheduler.sv
// Fractional-accumulator audio sample strobe in the pixel clock domain, feeding a small stereo FIFO
// whose head is presented once per strobe; empty-FIFO strobes are counted as underruns.
module audio_sample_scheduler #(
  parameter int unsigned PIXEL_RATE      = 74250000,
  parameter int unsigned AUDIO_RATE      = 48000,
  parameter int unsigned AUDIO_BIT_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned ACC_WIDTH       = 32,
  localparam int unsigned LEVEL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk_pixel,
  input  logic                       reset_n,
  input  logic                       enable,
  audio_sample_scheduler_if.slave    audio,
  output logic [LEVEL_W-1:0]         fifo_level,
  output logic [7:0]                 underrun_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned WORD_W = 2 * AUDIO_BIT_WIDTH;
  localparam logic [ACC_WIDTH-1:0] INC = ACC_WIDTH'(AUDIO_RATE);
  localparam logic [ACC_WIDTH-1:0] WRAP = ACC_WIDTH'(PIXEL_RATE);
  localparam logic [LEVEL_W-1:0] FULL = LEVEL_W'(FIFO_DEPTH);

  // acc + AUDIO_RATE must never overflow, otherwise the tick compare silently breaks
  if (ACC_WIDTH > 62 ||
      (64'(PIXEL_RATE) + 64'(AUDIO_RATE)) >= (64'd1 << ACC_WIDTH)) begin : g_bad_acc_width
    $error("audio_sample_scheduler: PIXEL_RATE + AUDIO_RATE does not fit in ACC_WIDTH");
  end
  if (AUDIO_RATE == 0 || AUDIO_RATE >= PIXEL_RATE) begin : g_bad_rates
    $error("audio_sample_scheduler: need 0 < AUDIO_RATE < PIXEL_RATE");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("audio_sample_scheduler: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [ACC_WIDTH-1:0]       acc;
  logic [ACC_WIDTH-1:0]       acc_next;
  logic                       tick;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [WORD_W-1:0]          mem [FIFO_DEPTH];
  logic                       strobe;
  logic [AUDIO_BIT_WIDTH-1:0] left;
  logic [AUDIO_BIT_WIDTH-1:0] right;

  assign acc_next = acc + INC;
  assign tick     = enable && (acc_next >= WRAP);
  assign empty    = (fifo_level == '0);
  assign push     = audio.src_valid && audio.src_ready;
  assign pop      = tick && !empty;

  assign audio.src_ready     = (fifo_level != FULL);
  assign audio.sample_strobe = strobe;
  assign audio.audio_left    = left;
  assign audio.audio_right   = right;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (enable) begin
      acc <= tick ? (acc_next - WRAP) : acc_next;
    end
  end

  // Storage carries no reset; entries are only read once the level says they were written.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      mem[wr_ptr] <= {audio.src_left, audio.src_right};
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      strobe         <= 1'b0;
      left           <= '0;
      right          <= '0;
      underrun_count <= '0;
    end else begin
      strobe <= tick;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        {left, right} <= mem[rd_ptr];
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LEVEL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LEVEL_W'(1);
      end
      // A push landing on an empty tick edge is too late for this strobe: still an underrun.
      if (tick && empty && underrun_count != 8'hFF) begin
        underrun_count <= underrun_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench: a small-ratio instance (10/3) for FIFO/cadence behaviour with a strobe scoreboard,
// plus a default-rate instance for the 48 kHz in 74.25 MHz interval check.
module tb_audio_sample_scheduler;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic [7:0]  ur;
  } exp_t;

  logic clk;
  logic reset_n;
  logic enable;
  logic enable_b;
  logic [2:0] fifo_level;
  logic [7:0] underrun_count;
  logic [2:0] fifo_level_b;
  logic [7:0] underrun_count_b;

  int   passed;
  int   total;
  bit   mon_run;
  exp_t sb[$];

  audio_sample_scheduler_if #(.AUDIO_BIT_WIDTH(16)) bus_a ();
  audio_sample_scheduler_if #(.AUDIO_BIT_WIDTH(16)) bus_b ();

  audio_sample_scheduler #(
    .PIXEL_RATE(10), .AUDIO_RATE(3), .AUDIO_BIT_WIDTH(16), .FIFO_DEPTH(4), .ACC_WIDTH(32)
  ) dut_a (
    .clk_pixel(clk), .reset_n(reset_n), .enable(enable), .audio(bus_a.slave),
    .fifo_level(fifo_level), .underrun_count(underrun_count)
  );

  audio_sample_scheduler dut_b (
    .clk_pixel(clk), .reset_n(reset_n), .enable(enable_b), .audio(bus_b.slave),
    .fifo_level(fifo_level_b), .underrun_count(underrun_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_out(input logic [15:0] l, input logic [15:0] r, input logic [7:0] ur);
    exp_t e;
    e.l = l; e.r = r; e.ur = ur;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    while (mon_run) begin
      @(negedge clk);
      if (bus_a.sample_strobe === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_strobe: strobe seen with no expected sample (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("strobe_word", {bus_a.audio_left, bus_a.audio_right, underrun_count}, e);
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Enable for n edges; optionally present one sample on the last of them.
  task automatic run(input int n, input bit push_last, input logic [15:0] val);
    enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (push_last && i == n - 1) begin
        bus_a.src_valid = 1'b1;
        bus_a.src_left  = val;
        bus_a.src_right = val;
      end
      @(posedge clk);
      #1;
    end
    enable = 1'b0;
    if (push_last) bus_a.src_valid = 1'b0;
  endtask

  task automatic push_one(input logic [15:0] val);
    bus_a.src_valid = 1'b1;
    bus_a.src_left  = val;
    bus_a.src_right = val;
    step(1);
    bus_a.src_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    int strobes;
    bit found;
    passed = 0;
    total = 0;
    mon_run = 1'b1;
    reset_n = 1'b1;
    enable = 1'b0;
    enable_b = 1'b0;
    bus_a.src_valid = 1'b0;
    bus_a.src_left = '0;
    bus_a.src_right = '0;
    bus_b.src_valid = 1'b0;
    bus_b.src_left = '0;
    bus_b.src_right = '0;
    fork monitor(); join_none

    #1 reset_n = 1'b0;
    #2;
    check("rst_strobe", bus_a.sample_strobe, 1'b0);
    check("rst_left", bus_a.audio_left, 16'h0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_underrun", underrun_count, 8'd0);
    check("rst_ready", bus_a.src_ready, 1'b1);
    step(2);

    // cadence 10/3 from reset: ticks on enabled edges 4,7,10,14,17,20
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) expect_out(16'h0, 16'h0, 8'(i));
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("cadence_edge%0d", k), bus_a.sample_strobe,
            (k == 4 || k == 7 || k == 10 || k == 14 || k == 17 || k == 20));
    end
    enable = 1'b0;

    // back-pressure: 1..4 accepted, 5 stalls until the next pop
    bus_a.src_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus_a.src_left = 16'(i);
      bus_a.src_right = 16'(i);
      step(1);
    end
    check("bp_level_full", fifo_level, 3'd4);
    check("bp_ready_low", bus_a.src_ready, 1'b0);
    bus_a.src_left = 16'h5;
    bus_a.src_right = 16'h5;
    step(3);
    check("bp_level_held", fifo_level, 3'd4);
    expect_out(16'h1, 16'h1, 8'd6);
    run(4, 1'b0, 16'h0);
    check("bp_ready_back", bus_a.src_ready, 1'b1);
    check("bp_level_after_pop", fifo_level, 3'd3);
    step(1);
    check("bp_level_after_push5", fifo_level, 3'd4);
    bus_a.src_valid = 1'b0;

    // drain 2, then push and pop on the same edge
    expect_out(16'h2, 16'h2, 8'd6);
    run(3, 1'b0, 16'h0);
    expect_out(16'h3, 16'h3, 8'd6);
    run(3, 1'b1, 16'h00A0);
    check("pushpop_level", fifo_level, 3'd3);
    expect_out(16'h4, 16'h4, 8'd6);
    run(4, 1'b0, 16'h0);
    expect_out(16'h5, 16'h5, 8'd6);
    run(3, 1'b0, 16'h0);
    expect_out(16'h00A0, 16'h00A0, 8'd6);
    run(3, 1'b0, 16'h0);
    check("drained_level", fifo_level, 3'd0);

    // push on an empty tick edge: underrun, sample kept for the next strobe
    expect_out(16'h00A0, 16'h00A0, 8'd7);
    run(4, 1'b1, 16'hBEEF);
    check("empty_push_level", fifo_level, 3'd1);
    check("empty_push_underrun", underrun_count, 8'd7);
    expect_out(16'hBEEF, 16'hBEEF, 8'd7);
    run(3, 1'b0, 16'h0);

    // underrun saturation with 0x1234 held on the outputs
    push_one(16'h1234);
    expect_out(16'h1234, 16'h1234, 8'd7);
    run(3, 1'b0, 16'h0);
    for (int i = 1; i <= 300; i++) expect_out(16'h1234, 16'h1234, (7 + i > 255) ? 8'd255 : 8'(7 + i));
    run(1000, 1'b0, 16'h0);
    check("underrun_saturated", underrun_count, 8'd255);
    check("underrun_hold_left", bus_a.audio_left, 16'h1234);

    // enable gating: freeze after edge 5, resume ticks on edges 7 and 10
    expect_out(16'h1234, 16'h1234, 8'd255);
    run(5, 1'b0, 16'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus_a.sample_strobe !== 1'b0) cnt++;
    end
    check("gated_no_strobes", cnt, 0);
    expect_out(16'h1234, 16'h1234, 8'd255);
    expect_out(16'h1234, 16'h1234, 8'd255);
    enable = 1'b1;
    for (int k = 6; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("resume_edge%0d", k), bus_a.sample_strobe, (k == 7 || k == 10));
    end
    enable = 1'b0;

    // asynchronous reset with 3 entries queued, between edges
    push_one(16'h0011);
    push_one(16'h0022);
    push_one(16'h0033);
    check("pre_reset_level", fifo_level, 3'd3);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_level", fifo_level, 3'd0);
    check("async_rst_left", bus_a.audio_left, 16'h0);
    check("async_rst_right", bus_a.audio_right, 16'h0);
    check("async_rst_underrun", underrun_count, 8'd0);
    check("async_rst_ready", bus_a.src_ready, 1'b1);
    step(2);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) expect_out(16'h0, 16'h0, 8'(i));
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_edge%0d", k), bus_a.sample_strobe, (k == 4 || k == 7 || k == 10));
    end
    enable = 1'b0;

    // default rates: first strobe after edge 1547, eight intervals total 12375
    enable_b = 1'b1;
    cnt = 0;
    found = 1'b0;
    while (cnt < 2000 && !found) begin
      step(1);
      cnt++;
      if (bus_b.sample_strobe === 1'b1) found = 1'b1;
    end
    check("default_first_strobe", cnt, 1547);
    cnt = 0;
    strobes = 0;
    while (cnt < 13000 && strobes < 8) begin
      step(1);
      cnt++;
      if (bus_b.sample_strobe === 1'b1) strobes++;
    end
    check("default_8_intervals", cnt, 12375);
    enable_b = 1'b0;

    step(3);
    check("scoreboard_drained", sb.size(), 0);
    mon_run = 1'b0;
    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/audio_sample_scheduler.md
Name: audio_sample_scheduler

Overview:
- Generates the audio sample-rate clock enable inside the clk_pixel domain using an exact fractional accumulator. No gated or divided clock is produced.
- Buffers stereo PCM samples from an audio source (sawtooth generator, tone ROM, etc.) in a small FIFO with a valid/ready handshake.
- Presents one stereo sample word per strobe to the hdmi audio path.
- Tracks FIFO underruns so the top level can flag them on an LED.

Parameters:
- PIXEL_RATE, 74250000: pixel clock frequency in Hz (720p default).
- AUDIO_RATE, 48000: target sample rate in Hz. Must satisfy 0 < AUDIO_RATE < PIXEL_RATE.
- AUDIO_BIT_WIDTH, 16: width of each channel sample.
- FIFO_DEPTH, 4: sample FIFO entries. Power of two, ≥ 2.
- ACC_WIDTH, 32: phase accumulator width. Requires PIXEL_RATE + AUDIO_RATE < 2^ACC_WIDTH, checked at elaboration.

Ports:
- clk_pixel  in  1  pixel clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, accumulator frozen and no strobes.
- src_valid  in  1  source presents a sample.
- src_left  in  AUDIO_BIT_WIDTH  left sample.
- src_right  in  AUDIO_BIT_WIDTH  right sample.
- src_ready  out  1  FIFO can accept a sample.
- sample_strobe  out  1  one-cycle pulse at AUDIO_RATE average.
- audio_left  out  AUDIO_BIT_WIDTH  current left word.
- audio_right  out  AUDIO_BIT_WIDTH  current right word.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- underrun_count  out  8  saturating underrun counter.

Behaviour:
- Reset (asynchronous, reset_n low): accumulator=0, sample_strobe=0, audio_left/right=0, FIFO empty, fifo_level=0, underrun_count=0. Outputs take reset values immediately, with no clock edge.
- src_ready = (fifo_level != FIFO_DEPTH). Combinational, so it reads 1 while in reset.
- Accumulator, on each clk_pixel edge with enable=1:
  - acc_next = acc + AUDIO_RATE.
  - tick = (acc_next >= PIXEL_RATE).
  - acc <= tick ? acc_next - PIXEL_RATE : acc_next.
  - Result: exactly AUDIO_RATE ticks per PIXEL_RATE enabled cycles, with no long-term drift.
- enable=0: acc holds and tick=0. The FIFO still accepts pushes.
- sample_strobe is registered: high for the single cycle following an edge where tick=1. Defaults give intervals of 1546 or 1547 cycles; the first strobe follows the 1547th enabled edge.
- Push: on an edge with src_valid && src_ready, {src_left, src_right} is written at the tail.
- Pop decision uses occupancy sampled before the edge (pre-edge fifo_level). On a tick edge:
  - Non-empty: head moves to audio_left/right on the same edge sample_strobe rises, and the entry is popped.
  - Empty: audio_left/right hold their previous value, and underrun_count increments, saturating at 255.
- Push on a tick edge with an empty FIFO: counts as an underrun. The pushed sample is stored and fifo_level becomes 1.
- Push and pop on the same edge with a non-empty, non-full FIFO: fifo_level unchanged, FIFO order preserved.
- Full FIFO: src_ready=0, so no push. A pop on that edge raises src_ready the following cycle.
- Output timing: audio_left/right are valid from the strobe cycle until the next strobe. Downstream samples them with sample_strobe as a clock enable.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is held as a separate counter (or pointer difference with extra MSB) so that full and empty are distinguishable.

Test Plan:
- Cadence: PIXEL_RATE=10, AUDIO_RATE=3, enable=1 from reset release → ticks on enabled edges 4,7,10,14,17,20; strobe intervals 3,3,4 repeating. With defaults, 8 consecutive strobe intervals sum to 12375 cycles.
- Back-pressure: hold src_valid=1 with samples 0x0001..0x0005, no strobes → 4 accepted, src_ready=0 after the 4th, fifo_level=4. The next strobe outputs 0x0001 on both channels, src_ready returns to 1, and 0x0005 is then accepted.
- Underrun: empty FIFO with previous output 0x1234 → each strobe keeps audio_left=0x1234 and increments underrun_count. After 300 strobes underrun_count=255.
- Simultaneous push and pop on empty: push 0xBEEF on a tick edge → underrun_count +1, fifo_level=1, outputs unchanged. The next strobe outputs 0xBEEF.
- Enable gating (PIXEL_RATE=10, AUDIO_RATE=3): drop enable after edge 5 for 20 cycles → no strobes, acc frozen at 5. Resumed ticks fall on enabled edges 7,10 relative to the enabled count.
- Asynchronous reset: assert reset_n=0 mid-run with the FIFO at 3 entries, between clock edges → all outputs zero and fifo_level=0 before the next edge. After release, cadence restarts from acc=0.
